// File: rtl/gray_pkg.sv
// Shared types and gray-code helper for the gray counter checker and its decoder.
// Purely declarative: no latency, no backpressure.
package gray_pkg;

    localparam int MAX_W = 16;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SYNCING  = 2'd1,
        LOCKED   = 2'd2
    } chk_state_t;

    typedef enum logic [1:0] {
        GOOD = 2'd0,
        HOLD = 2'd1,
        BAD  = 2'd2
    } step_cls_t;

    // Operands narrower than MAX_W are zero-extended, which leaves the low bits correct.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational gray-to-binary decoder, N bits wide.
// Zero latency; no flow control.
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    logic [MAX_W-1:0] bin_full;

    assign bin_full = gray2bin(MAX_W'(gray));
    assign bin      = bin_full[N-1:0];

endmodule

// File: rtl/gray_count_checker.sv
// Decodes a gray count stream and checks each accepted sample is the +1 successor.
// One-cycle registered latency; no backpressure, a sample is taken whenever gray_valid is high.
module gray_count_checker
    import gray_pkg::*;
#(
    parameter int N          = 3,
    parameter int LOCK_COUNT = 2,
    parameter bit ALLOW_HOLD = 1'b1,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gray_valid,
    input  logic [N-1:0]     gray_in,
    output logic [N-1:0]     bin_out,
    output logic             bin_valid,
    output logic             locked,
    output logic             step_err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count
);

    chk_state_t       state_q, state_d;
    logic [N-1:0]     prev_bin_q, prev_bin_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic [N-1:0]     bin_out_q, bin_out_d;
    logic             bin_valid_q, bin_valid_d;
    logic             locked_q, locked_d;
    logic             step_err_q, step_err_d;
    logic             wrap_q, wrap_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic [N-1:0] dec;
    logic [N-1:0] exp_bin;
    logic [3:0]   good_inc;
    step_cls_t    cls;

    gray_to_bin #(.N(N)) u_dec (
        .gray (gray_in),
        .bin  (dec)
    );

    assign exp_bin  = prev_bin_q + N'(1);
    assign good_inc = good_cnt_q + 4'd1;

    always_comb begin
        if (dec == exp_bin)
            cls = GOOD;
        else if (ALLOW_HOLD && (dec == prev_bin_q))
            cls = HOLD;
        else
            cls = BAD;
    end

    always_comb begin
        state_d     = state_q;
        prev_bin_d  = prev_bin_q;
        good_cnt_d  = good_cnt_q;
        bin_out_d   = bin_out_q;
        bin_valid_d = 1'b0;
        locked_d    = locked_q;
        step_err_d  = 1'b0;
        wrap_d      = 1'b0;
        err_count_d = err_count_q;

        if (gray_valid) begin
            bin_valid_d = 1'b1;
            case (state_q)
                UNLOCKED: begin
                    bin_out_d  = dec;
                    prev_bin_d = dec;
                    good_cnt_d = 4'd0;
                    state_d    = SYNCING;
                end
                SYNCING: begin
                    if (cls == GOOD) begin
                        bin_out_d  = dec;
                        prev_bin_d = dec;
                        wrap_d     = (prev_bin_q == {N{1'b1}});
                        good_cnt_d = good_inc;
                        if (good_inc == 4'(LOCK_COUNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else if (cls == BAD) begin
                        // Still acquiring: reseed silently rather than flag an error.
                        bin_out_d  = dec;
                        prev_bin_d = dec;
                        good_cnt_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (cls == GOOD) begin
                        bin_out_d  = dec;
                        prev_bin_d = dec;
                        wrap_d     = (prev_bin_q == {N{1'b1}});
                    end else if (cls == BAD) begin
                        bin_out_d  = dec;
                        prev_bin_d = dec;
                        good_cnt_d = 4'd0;
                        step_err_d = 1'b1;
                        locked_d   = 1'b0;
                        state_d    = SYNCING;
                        if (err_count_q != {ERR_W{1'b1}})
                            err_count_d = err_count_q + ERR_W'(1);
                    end
                end
                default: begin
                    state_d  = UNLOCKED;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= UNLOCKED;
            prev_bin_q  <= '0;
            good_cnt_q  <= '0;
            bin_out_q   <= '0;
            bin_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            step_err_q  <= 1'b0;
            wrap_q      <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_bin_q  <= prev_bin_d;
            good_cnt_q  <= good_cnt_d;
            bin_out_q   <= bin_out_d;
            bin_valid_q <= bin_valid_d;
            locked_q    <= locked_d;
            step_err_q  <= step_err_d;
            wrap_q      <= wrap_d;
            err_count_q <= err_count_d;
        end
    end

    assign bin_out   = bin_out_q;
    assign bin_valid = bin_valid_q;
    assign locked    = locked_q;
    assign step_err  = step_err_q;
    assign wrap      = wrap_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_gray_count_checker.sv
// Directed scoreboard bench: three checker instances (hold allowed, hold illegal, 2-bit error counter).
// Stimulus pushes expected outputs per instance; negedge monitors pop and compare on bin_valid.
module tb_gray_count_checker;

    typedef struct packed {
        logic [2:0] bin;
        logic       lck;
        logic       serr;
        logic       wrp;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] vld = 3'b000;
    logic [2:0] gin = 3'b000;

    logic [2:0] bin_a, bin_b, bin_c;
    logic       bv_a, bv_b, bv_c;
    logic       lk_a, lk_b, lk_c;
    logic       se_a, se_b, se_c;
    logic       wr_a, wr_b, wr_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int checks = 0;
    int errors = 0;
    int pulses_c = 0;

    always #5 clk = ~clk;

    gray_count_checker #(.N(3), .LOCK_COUNT(2), .ALLOW_HOLD(1'b1), .ERR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .gray_valid(vld[0]), .gray_in(gin),
        .bin_out(bin_a), .bin_valid(bv_a), .locked(lk_a), .step_err(se_a),
        .wrap(wr_a), .err_count(cnt_a)
    );

    gray_count_checker #(.N(3), .LOCK_COUNT(2), .ALLOW_HOLD(1'b0), .ERR_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .gray_valid(vld[1]), .gray_in(gin),
        .bin_out(bin_b), .bin_valid(bv_b), .locked(lk_b), .step_err(se_b),
        .wrap(wr_b), .err_count(cnt_b)
    );

    gray_count_checker #(.N(3), .LOCK_COUNT(2), .ALLOW_HOLD(1'b1), .ERR_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .gray_valid(vld[2]), .gray_in(gin),
        .bin_out(bin_c), .bin_valid(bv_c), .locked(lk_c), .step_err(se_c),
        .wrap(wr_c), .err_count(cnt_c)
    );

    function automatic exp_t ex(input logic [2:0] b, input logic l, input logic s,
                                input logic w, input logic [7:0] c);
        exp_t e;
        e.bin = b; e.lck = l; e.serr = s; e.wrp = w; e.cnt = c;
        return e;
    endfunction

    task automatic compare(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got bin=%0d locked=%0b step_err=%0b wrap=%0b err_count=%0d, want bin=%0d locked=%0b step_err=%0b wrap=%0b err_count=%0d",
                     name, act.bin, act.lck, act.serr, act.wrp, act.cnt,
                     exp.bin, exp.lck, exp.serr, exp.wrp, exp.cnt);
        end
    endtask

    task automatic check_idle(input string name, input logic serr, input logic wrp);
        checks++;
        if (serr !== 1'b0 || wrp !== 1'b0) begin
            errors++;
            $display("FAIL %s: pulse without bin_valid, step_err=%0b wrap=%0b, want 0 0", name, serr, wrp);
        end
    endtask

    always @(negedge clk) begin
        if (bv_a) begin
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut_a unexpected: bin_valid=1 bin=%0d, want no output", bin_a);
            end else compare("dut_a", {bin_a, lk_a, se_a, wr_a, cnt_a}, q_a.pop_front());
        end else check_idle("dut_a idle", se_a, wr_a);
    end

    always @(negedge clk) begin
        if (bv_b) begin
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut_b unexpected: bin_valid=1 bin=%0d, want no output", bin_b);
            end else compare("dut_b", {bin_b, lk_b, se_b, wr_b, cnt_b}, q_b.pop_front());
        end else check_idle("dut_b idle", se_b, wr_b);
    end

    always @(negedge clk) begin
        if (bv_c) begin
            if (se_c) pulses_c++;
            if (q_c.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut_c unexpected: bin_valid=1 bin=%0d, want no output", bin_c);
            end else compare("dut_c", {bin_c, lk_c, se_c, wr_c, {6'b0, cnt_c}}, q_c.pop_front());
        end else check_idle("dut_c idle", se_c, wr_c);
    end

    task automatic send(input int d, input logic [2:0] g, input exp_t e);
        vld    = 3'b000;
        vld[d] = 1'b1;
        gin    = g;
        case (d)
            0: q_a.push_back(e);
            1: q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        vld = 3'b000;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_a(input string name);
        logic [14:0] act;
        act = {bin_a, bv_a, lk_a, se_a, wr_a, cnt_a};
        checks++;
        if (act !== 15'd0) begin
            errors++;
            $display("FAIL %s: outputs=%h, want all zero", name, act);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_a("reset_init");
        rst_n = 1'b1;
        idle(1);

        // Acquire lock, then count through a full wrap.
        send(0, 3'b000, ex(3'd0, 0, 0, 0, 0));
        send(0, 3'b001, ex(3'd1, 0, 0, 0, 0));
        send(0, 3'b011, ex(3'd2, 1, 0, 0, 0));
        send(0, 3'b010, ex(3'd3, 1, 0, 0, 0));
        send(0, 3'b110, ex(3'd4, 1, 0, 0, 0));
        send(0, 3'b111, ex(3'd5, 1, 0, 0, 0));
        send(0, 3'b101, ex(3'd6, 1, 0, 0, 0));
        send(0, 3'b100, ex(3'd7, 1, 0, 0, 0));
        send(0, 3'b000, ex(3'd0, 1, 0, 1, 0));
        send(0, 3'b001, ex(3'd1, 1, 0, 0, 0));
        idle(2);
        send(0, 3'b011, ex(3'd2, 1, 0, 0, 0));
        send(0, 3'b010, ex(3'd3, 1, 0, 0, 0));

        // Bad jump 3 -> 5 while locked, then relock.
        send(0, 3'b111, ex(3'd5, 0, 1, 0, 1));
        send(0, 3'b101, ex(3'd6, 0, 0, 0, 1));
        send(0, 3'b100, ex(3'd7, 1, 0, 0, 1));

        // Wrap to 0, step to 2, then hold three times.
        send(0, 3'b000, ex(3'd0, 1, 0, 1, 1));
        send(0, 3'b001, ex(3'd1, 1, 0, 0, 1));
        send(0, 3'b011, ex(3'd2, 1, 0, 0, 1));
        send(0, 3'b011, ex(3'd2, 1, 0, 0, 1));
        send(0, 3'b011, ex(3'd2, 1, 0, 0, 1));
        send(0, 3'b011, ex(3'd2, 1, 0, 0, 1));
        send(0, 3'b010, ex(3'd3, 1, 0, 0, 1));
        idle(1);

        // Holds are errors when not allowed.
        send(1, 3'b000, ex(3'd0, 0, 0, 0, 0));
        send(1, 3'b001, ex(3'd1, 0, 0, 0, 0));
        send(1, 3'b011, ex(3'd2, 1, 0, 0, 0));
        send(1, 3'b011, ex(3'd2, 0, 1, 0, 1));
        send(1, 3'b011, ex(3'd2, 0, 0, 0, 1));
        send(1, 3'b011, ex(3'd2, 0, 0, 0, 1));
        send(1, 3'b010, ex(3'd3, 0, 0, 0, 1));
        send(1, 3'b110, ex(3'd4, 1, 0, 0, 1));
        idle(1);

        // Five lock/bad cycles against a 2-bit saturating counter.
        send(2, 3'b000, ex(3'd0, 0, 0, 0, 0));
        send(2, 3'b001, ex(3'd1, 0, 0, 0, 0));
        send(2, 3'b011, ex(3'd2, 1, 0, 0, 0));
        send(2, 3'b110, ex(3'd4, 0, 1, 0, 1));
        send(2, 3'b111, ex(3'd5, 0, 0, 0, 1));
        send(2, 3'b101, ex(3'd6, 1, 0, 0, 1));
        send(2, 3'b000, ex(3'd0, 0, 1, 0, 2));
        send(2, 3'b001, ex(3'd1, 0, 0, 0, 2));
        send(2, 3'b011, ex(3'd2, 1, 0, 0, 2));
        send(2, 3'b111, ex(3'd5, 0, 1, 0, 3));
        send(2, 3'b101, ex(3'd6, 0, 0, 0, 3));
        send(2, 3'b100, ex(3'd7, 1, 0, 0, 3));
        send(2, 3'b011, ex(3'd2, 0, 1, 0, 3));
        send(2, 3'b010, ex(3'd3, 0, 0, 0, 3));
        send(2, 3'b110, ex(3'd4, 1, 0, 0, 3));
        send(2, 3'b000, ex(3'd0, 0, 1, 0, 3));
        idle(2);

        // Reset beats a valid sample on the same edge; next sample reseeds.
        vld   = 3'b001;
        gin   = 3'b110;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        vld   = 3'b000;
        check_reset_a("reset_vs_valid");
        send(0, 3'b101, ex(3'd6, 0, 0, 0, 0));
        send(0, 3'b100, ex(3'd7, 0, 0, 0, 0));
        send(0, 3'b000, ex(3'd0, 1, 0, 1, 0));
        idle(3);

        checks++;
        if (q_a.size() + q_b.size() + q_c.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected outputs never seen, want 0",
                     q_a.size() + q_b.size() + q_c.size());
        end
        checks++;
        if (pulses_c != 5) begin
            errors++;
            $display("FAIL step_err_pulses: got %0d, want 5", pulses_c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_count_checker.md
Name: gray_count_checker

Overview:
- Receive end of the gray-code counter interface: samples an N-bit gray-coded count stream and decodes it to binary.
- Checks that every accepted sample is the legal +1 (single-bit) gray successor of the previous one.
- Tracks lock and error status and flags counter wrap-around.
- Sits downstream of a gray-code counter, typically across a clock-domain synchronizer or in a bench monitor.

Parameters:
- N, 3: count width in bits; legal range 2..16.
- LOCK_COUNT, 2: number of consecutive good steps needed to declare lock; legal range 1..15.
- ALLOW_HOLD, 1: 1 means a repeated identical sample is a legal hold; 0 means a repeat is an error.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- gray_valid  in  1  gray_in is sampled on this cycle.
- gray_in  in  N  gray-coded count.
- bin_out  out  N  decoded binary value of the last accepted sample.
- bin_valid  out  1  one-cycle strobe: bin_out was updated.
- locked  out  1  checker is in the LOCKED state.
- step_err  out  1  one-cycle pulse: illegal step detected while LOCKED.
- wrap  out  1  one-cycle pulse: legal step from all-ones to zero.
- err_count  out  ERR_W  number of step_err events, saturating.

Behaviour:
- Reset:
  - Synchronous, active-low; applied when rst_n=0 at a clk rising edge.
  - Reset wins over gray_valid on the same edge.
  - All outputs reset to 0; prev_bin=0, good_cnt=0, state=UNLOCKED.
- Decode: combinational gray-to-binary, b[N-1]=g[N-1], b[i]=b[i+1]^g[i].
  - All outputs are registered; latency from the gray_valid edge to bin_out/bin_valid is 1 cycle.
- Accepted sample (gray_valid=1):
  - bin_out <= dec, bin_valid <= 1.
  - Exception: a hold with ALLOW_HOLD=1 still pulses bin_valid, but bin_out is unchanged.
  - gray_valid=0: bin_valid <= 0; all other state holds.
- Step classification on an accepted sample, with exp = (prev_bin+1) mod 2^N:
  - GOOD if dec == exp.
  - HOLD if dec == prev_bin.
  - BAD otherwise.
  - HOLD is treated as BAD when ALLOW_HOLD=0.
- State machine:
  - UNLOCKED: the first accepted sample is the seed. prev_bin <= dec, good_cnt <= 0, go to SYNCING. No error is possible.
  - SYNCING on GOOD: good_cnt++. If good_cnt+1 == LOCK_COUNT, go to LOCKED and set locked <= 1.
  - SYNCING on BAD: good_cnt <= 0, reseed prev_bin <= dec, stay in SYNCING. No step_err, no err_count change.
  - SYNCING or LOCKED on HOLD (allowed): no state change, good_cnt unchanged.
  - LOCKED on GOOD: stay in LOCKED.
  - LOCKED on BAD: step_err <= 1 for one cycle, err_count++ (saturating at all-ones), locked <= 0, good_cnt <= 0, prev_bin <= dec, go to SYNCING.
- prev_bin is updated on every accepted sample except an allowed HOLD.
- wrap <= 1 for one cycle on a GOOD step with prev_bin == all-ones (so dec == 0), in either SYNCING or LOCKED. No wrap on a BAD step.
- step_err and wrap never assert without bin_valid asserting on the same cycle.
- err_count is never cleared except by reset.

Decomposition:
- Shared package gray_pkg:
  - State enum {UNLOCKED, SYNCING, LOCKED}, 2-bit encoding.
  - Step-class enum {GOOD, HOLD, BAD}.
  - Function gray2bin(N).
- Sub-module gray_to_bin (parameter N): purely combinational decoder. It is reused by the counter's bench.
- The checker holds the FSM, prev_bin, good_cnt and the counters.

Test Plan:
1. N=3, LOCK_COUNT=2, reset, then 000,001,011,010 with valid every cycle -> bin_out 0,1,2,3 (1-cycle latency). locked=1 in the same cycle bin_out=2 is presented. No step_err.
2. Locked, continue 110,111,101,100,000 -> bin_out 4,5,6,7,0. wrap=1 only on the bin_out=0 cycle.
3. Locked at bin 3 (010), feed 111 -> bin_out=5, step_err=1 for one cycle, err_count=1, locked=0. Then 101,100 -> locked=1 again with bin_out=7.
4. Locked at 011, repeat 011 three times: with ALLOW_HOLD=1 -> bin_valid=1 each cycle, bin_out=2, no error. With ALLOW_HOLD=0 -> step_err on the first repeat, err_count=1.
5. Locked with gray_valid=1, drive rst_n=0 for one edge -> next cycle all outputs 0. The following sample 101 is the seed (bin_out=6, no error, locked=0).
6. ERR_W=2, alternate relock/bad steps for 5 errors -> err_count reads 1,2,3,3,3 and step_err pulses 5 times.
